uart_rx: RTL and testbench

- Asynchronous serial receiver for the console UART: 8 data bits, no parity, 1 stop bit, LSB first, line idle high.
- Runs on the system clock. Uses the same 9-bit `bdiv` divisor value the transmit side uses, so one bit period is 2*(bdiv+1) clk cycles.
- Received bytes go into a small first-word-fall-through FIFO that the CPU bus reads.
- Reports framing errors and overruns through sticky flags.

---
 rtl/uart_rx.sv | 150 +++++++++++++++
 tb/tb_uart_rx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Console UART receiver: 8N1, LSB first, mid-bit sampling from a shared baud divisor,
// feeding a small first-word-fall-through FIFO with sticky framing/overrun flags.
module uart_rx #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] bdiv,
  input  logic       rx,
  input  logic       re,
  input  logic       err_clr,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       ferr,
  output logic       ovr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_reg, state_next;
  logic            rx_meta_reg, rx_s_reg;
  logic [9:0]      timer_reg, timer_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      shift_reg, shift_next;
  logic            push, ferr_set;
  logic            half, full;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  fifo_full, do_pop, push_en, ovr_set;
  logic                  ferr_reg, ovr_reg;

  assign half = (timer_reg == {1'b0, bdiv});
  assign full = (timer_reg == {bdiv, 1'b1});

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      state_reg   <= S_IDLE;
      timer_reg   <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg + 10'd1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    push       = 1'b0;
    ferr_set   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        timer_next = '0;
        if (!rx_s_reg) state_next = S_START;
      end
      S_START: begin
        if (half) begin
          timer_next = '0;
          bit_next   = '0;
          state_next = rx_s_reg ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (full) begin
          timer_next = '0;
          shift_next = {rx_s_reg, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = S_STOP;
        end
      end
      S_STOP: begin
        // Leave mid stop bit so a start bit immediately following is not missed.
        if (full) begin
          timer_next = '0;
          if (rx_s_reg) begin
            push       = 1'b1;
            state_next = S_IDLE;
          end else begin
            ferr_set   = 1'b1;
            state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        timer_next = '0;
        if (rx_s_reg) state_next = S_IDLE;
      end
      default: begin
        timer_next = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  assign fifo_full = (count_reg == CNT_W'(DEPTH));
  assign do_pop    = re && (count_reg != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push_en   = push && (!fifo_full || do_pop);
  assign ovr_set   = push && fifo_full && !do_pop;

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_reg] <= shift_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      ferr_reg   <= 1'b0;
      ovr_reg    <= 1'b0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_en, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      ferr_reg <= ferr_set || (ferr_reg && !err_clr);
      ovr_reg  <= ovr_set  || (ovr_reg  && !err_clr);
    end
  end

  assign rvalid = (count_reg != '0);
  assign rdata  = rvalid ? mem[rd_ptr_reg] : 8'h00;
  assign ferr   = ferr_reg;
  assign ovr    = ovr_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit at 2*(bdiv+1) clks per bit
// and FIFO contents and flags are compared with hand-computed values.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] bdiv;
  logic       rx;
  logic       re;
  logic       err_clr;
  logic [7:0] rdata;
  logic       rvalid;
  logic       ferr;
  logic       ovr;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx #(.DEPTH_LOG2(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .bdiv    (bdiv),
    .rx      (rx),
    .re      (re),
    .err_clr (err_clr),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .ferr    (ferr),
    .ovr     (ovr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; with chk, verifies rvalid rises exactly on the stop-bit sample edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic chk, input logic pop);
    int p;
    p = 2 * (int'(bdiv) + 1);
    rx = 1'b0;
    tick(p);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(p);
    end
    rx = stop;
    tick(int'(bdiv) + 3);
    if (chk) check_eq("rvalid_before_push", rvalid, 0);
    if (pop) re = 1'b1;
    tick(1);
    re = 1'b0;
    if (chk) begin
      check_eq("rvalid_after_push", rvalid, 1);
      check_eq("rdata_after_push", rdata, d);
      check_eq("ferr_after_push", ferr, 0);
      check_eq("ovr_after_push", ovr, 0);
    end
    tick(p - int'(bdiv) - 4);
    rx = 1'b1;
    $display("sent frame 0x%02h stop=%0d bdiv=%0d", d, stop, bdiv);
  endtask

  task automatic read_check(input string tag, input logic [7:0] exp);
    check_eq({tag, "_rvalid"}, rvalid, 1);
    check_eq({tag, "_rdata"}, rdata, exp);
    $display("read 0x%02h (expected 0x%02h)", rdata, exp);
    re = 1'b1;
    tick(1);
    re = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    bdiv    = 9'd3;
    rx      = 1'b1;
    re      = 1'b0;
    err_clr = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    check_eq("reset_rvalid", rvalid, 0);
    check_eq("reset_ferr", ferr, 0);
    check_eq("reset_ovr", ovr, 0);
    check_eq("reset_rdata", rdata, 0);

    // Basic receive
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    read_check("basic", 8'hA5);
    check_eq("basic_empty", rvalid, 0);
    re = 1'b1;
    tick(1);
    re = 1'b0;
    check_eq("empty_re_rvalid", rvalid, 0);
    tick(4);

    // Glitch reject
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(20);
    check_eq("glitch_rvalid", rvalid, 0);
    check_eq("glitch_ferr", ferr, 0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    read_check("after_glitch", 8'h3C);
    tick(4);

    // Framing error followed by a held-low break
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    tick(40);
    rx = 1'b1;
    tick(16);
    check_eq("break_ferr", ferr, 1);
    check_eq("break_rvalid", rvalid, 0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    read_check("after_break", 8'h55);
    check_eq("ferr_still_set", ferr, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check_eq("ferr_cleared", ferr, 0);
    tick(4);

    // Overrun: five frames into four entries
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    check_eq("ovr_set", ovr, 1);
    for (int i = 1; i <= 4; i++) read_check("ovr_read", 8'(i));
    check_eq("ovr_drained", rvalid, 0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check_eq("ovr_cleared", ovr, 0);

    // Same again, popping on the cycle of the fifth push
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    send_frame(8'h05, 1'b1, 1'b0, 1'b1);
    check_eq("pop_push_ovr", ovr, 0);
    for (int i = 2; i <= 5; i++) read_check("pop_push_read", 8'(i));
    check_eq("pop_push_drained", rvalid, 0);
    tick(4);

    // Zero-gap frames at two baud rates
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    read_check("gap3_a", 8'h00);
    read_check("gap3_b", 8'hFF);
    check_eq("gap3_ferr", ferr, 0);
    check_eq("gap3_ovr", ovr, 0);
    bdiv = 9'd100;
    tick(4);
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    read_check("gap100_a", 8'h00);
    read_check("gap100_b", 8'hFF);
    check_eq("gap100_ferr", ferr, 0);
    check_eq("gap100_ovr", ovr, 0);
    check_eq("gap100_empty", rvalid, 0);
    bdiv = 9'd3;
    tick(4);

    // Reset in the middle of data bit 4 of 0x77, with a byte already queued
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    check_eq("pre_reset_rvalid", rvalid, 1);
    rx = 1'b0;
    tick(8);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'h77 >> i);
      tick(8);
    end
    rx = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(100);
    check_eq("midreset_rvalid", rvalid, 0);
    check_eq("midreset_ferr", ferr, 0);
    check_eq("midreset_ovr", ovr, 0);
    send_frame(8'h81, 1'b1, 1'b1, 1'b0);
    read_check("after_reset", 8'h81);
    check_eq("final_empty", rvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
